snn_mem_mp: RTL and testbench
=============================

// Module: snn_mem_mp
// PURPOSE
//  Clocked, parametrised multi-port memory for SNN neuron/weight storage.
//  One write channel (addr+data) and NUM_RD independent read channels, all valid/ready.
//  Each read port has a registered 1-entry response slot, so back-pressure is handled per port.
//  Sits between the NoC packet decoder (writes) and the PE/accumulator read clients.
// PARAMETERS
//  WIDTH   8   data word width in bits
//  DEPTH   16  number of words; need not be a power of two
//  NUM_RD  2   number of read channels (1..8)
//  ADDR_W  $clog2(DEPTH) (min 1)  address width; derived, do not override
// PORTS
//  clk            in   1              the single clock; all logic is rising-edge
//  rst_n          in   1              reset, asynchronous assert, active-low
//  wr_valid       in   1              write request valid
//  wr_ready       out  1              constant 1 outside reset; 0 while rst_n=0
//  wr_addr        in   ADDR_W         write address
//  wr_data        in   WIDTH          write data
//  rd_req_valid   in   NUM_RD         per-port read request valid
//  rd_req_ready   out  NUM_RD         per-port read request ready
//  rd_req_addr    in   NUM_RD*ADDR_W  per-port read address; port i is slice i
//  rd_rsp_valid   out  NUM_RD         per-port response valid
//  rd_rsp_ready   in   NUM_RD         per-port response ready
//  rd_rsp_data    out  NUM_RD*WIDTH   per-port response data; port i is slice i
//  addr_err       out  1              [ADDR_CHECK_EN only] 1-cycle pulse on an out-of-range access
//  err_cnt        out  8              [ADDR_CHECK_EN only] saturating count of out-of-range accesses
// BEHAVIOUR
//  Reset, async on rst_n=0:
//   - all mem words=0; rd_rsp_valid=0; rd_rsp_data=0; wr_ready=0
//   - rd_req_ready=0; addr_err=0; err_cnt=0
//   - A reset asserted mid-operation discards pending responses; no partial writes.
//  Write:
//   - Transfer happens when wr_valid&&wr_ready at a clk edge.
//   - mem[wr_addr] is updated at that edge.
//  Read slot, per port i, state EMPTY/FULL:
//   - rd_req_ready[i] = !FULL || rd_rsp_ready[i] (pipelined; full throughput).
//   - An accepted request loads slot data = mem[addr]; the slot goes FULL the next cycle (latency 1).
//   - FULL && rsp_ready && !new accept -> EMPTY.
//   - FULL && rsp_ready && accept -> stays FULL with the new data (back-to-back).
//   - FULL && !rsp_ready -> hold valid and data stable; rd_req_ready=0.
//  Simultaneous events:
//   - A write and any read of the same address in the same cycle: the read returns the NEW data
//     (write-first bypass).
//   - Multiple ports may read the same or different addresses in the same cycle; there is no
//     arbitration and no stall.
//  Address range:
//   - An address >= DEPTH is out of range.
//   - An out-of-range write is dropped.
//   - An out-of-range read returns 0 and completes the handshake normally.
//  rd_rsp_data holds its last value while valid=0; consumers must not sample it then.
// CONFIGURATION
//  Macro SNN_MEM_ADDR_CHECK_EN:
//   - Defined: adds the addr_err and err_cnt ports.
//   - addr_err pulses for 1 cycle if any accepted write or read in that cycle is out of range.
//   - err_cnt increments by the number of such accesses that cycle and saturates at 255.
//   - Undefined: both ports are absent; out-of-range behaviour is otherwise identical.
// STRUCTURE
//  Package snn_mem_pkg:
//   - function addr_w(depth) = max(1, $clog2(depth))
//   - typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_st_t
//   - localparam ERR_CNT_W = 8
//  Sub-module snn_mem_rd_slot (WIDTH):
//   - one per read port, created by a generate loop over NUM_RD
//   - holds the slot FSM, the ready equation and the data register
//  Top level holds the array, the write path, the bypass mux and the error logic.
// TESTING
//  1 Reset: hold rst_n=0 for 3 cycles, then release.
//    -> all rd_rsp_valid=0; reads of addr 0..15 return 0.
//  2 Write 8'hA5 to addr 3, then port0 reads addr 3 the next cycle.
//    -> rd_rsp_valid[0]=1 one cycle after accept; data=A5.
//  3 Same cycle: write 8'h3C to addr 7, port0 and port1 both read addr 7.
//    -> both ports return 3C (write-first).
//  4 Port1 issues 4 back-to-back reads of addr 0..3, with rsp_ready=0 for cycles 2-4.
//    -> data held stable, rd_req_ready[1]=0 while stalled, 4 responses in order, none lost.
//  5 DEPTH=10: write 8'hFF to addr 12, then read addr 12.
//    -> memory unchanged; rsp data=0.
//    -> with SNN_MEM_ADDR_CHECK_EN: addr_err pulses twice; err_cnt=2.
//  6 Assert rst_n=0 while port0 is FULL and stalled.
//    -> rd_rsp_valid[0] drops immediately (async); no response after release.

Source files
------------

// File: rtl/snn_mem_pkg.sv
// Shared types and helpers for the snn_mem multi-port memory.
// The optional SNN_MEM_ADDR_CHECK_EN build uses ERR_CNT_W for its error counter.
package snn_mem_pkg;

  localparam int ERR_CNT_W = 8;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_st_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/snn_mem_rd_slot.sv
// One-entry registered response slot for a single read port.
// The request side stays open while the slot is empty or is being drained this cycle.
module snn_mem_rd_slot
  import snn_mem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data
);

  slot_st_t         state_reg;
  slot_st_t         state_next;
  logic [WIDTH-1:0] data_reg;
  logic             req_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SLOT_EMPTY;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (req_fire) begin
        data_reg <= load_data;
      end
    end
  end

  always_comb begin
    req_ready  = rst_n && ((state_reg == SLOT_EMPTY) || rsp_ready);
    req_fire   = req_valid && req_ready;
    state_next = state_reg;
    case (state_reg)
      SLOT_EMPTY: if (req_fire) state_next = SLOT_FULL;
      SLOT_FULL:  if (rsp_ready && !req_fire) state_next = SLOT_EMPTY;
      default:    state_next = SLOT_EMPTY;
    endcase
  end

  assign rsp_valid = (state_reg == SLOT_FULL);
  assign rsp_data  = data_reg;

endmodule

// File: rtl/snn_mem_mp.sv
// Multi-port SNN memory: one write channel, NUM_RD read channels with per-port response slots.
// Define SNN_MEM_ADDR_CHECK_EN to add the addr_err / err_cnt out-of-range reporting ports.
module snn_mem_mp
  import snn_mem_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD-1:0]        rd_req_valid,
  output logic [NUM_RD-1:0]        rd_req_ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_req_addr,
  output logic [NUM_RD-1:0]        rd_rsp_valid,
  input  logic [NUM_RD-1:0]        rd_rsp_ready,
  output logic [NUM_RD*WIDTH-1:0]  rd_rsp_data
`ifdef SNN_MEM_ADDR_CHECK_EN
  ,
  output logic                     addr_err,
  output logic [ERR_CNT_W-1:0]     err_cnt
`endif
);

  // One extra bit so DEPTH itself is representable when it is a power of two.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_in_range;
  logic              wr_fire;
  logic [NUM_RD-1:0] rd_in_range;

  assign wr_ready    = rst_n;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
  assign wr_fire     = wr_valid && wr_ready && wr_in_range;

  // Words are reset individually, so the array is kept in flops.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem[gi] <= '0;
        end else if (wr_fire && (wr_addr == ADDR_W'(gi))) begin
          mem[gi] <= wr_data;
        end
      end
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_port
      logic [ADDR_W-1:0] rd_addr;
      logic [WIDTH-1:0]  load_data;

      assign rd_addr         = rd_req_addr[gi*ADDR_W +: ADDR_W];
      assign rd_in_range[gi] = ({1'b0, rd_addr} < DEPTH_EXT);

      // Same-cycle write to the same word is forwarded so the read sees the new data.
      always_comb begin
        load_data = '0;
        if (rd_in_range[gi]) begin
          if (wr_fire && (wr_addr == rd_addr)) begin
            load_data = wr_data;
          end else begin
            load_data = mem[rd_addr];
          end
        end
      end

      snn_mem_rd_slot #(
        .WIDTH(WIDTH)
      ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (rd_req_valid[gi]),
        .req_ready (rd_req_ready[gi]),
        .load_data (load_data),
        .rsp_valid (rd_rsp_valid[gi]),
        .rsp_ready (rd_rsp_ready[gi]),
        .rsp_data  (rd_rsp_data[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

`ifdef SNN_MEM_ADDR_CHECK_EN
  localparam int CNT_W = $clog2(NUM_RD + 2);

  logic [CNT_W-1:0]   err_now;
  logic [ERR_CNT_W:0] err_sum;

  always_comb begin
    err_now = CNT_W'(wr_valid && wr_ready && !wr_in_range);
    for (int i = 0; i < NUM_RD; i++) begin
      err_now = err_now + CNT_W'(rd_req_valid[i] && rd_req_ready[i] && !rd_in_range[i]);
    end
    err_sum = {1'b0, err_cnt} + (ERR_CNT_W + 1)'(err_now);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      addr_err <= (err_now != '0);
      err_cnt  <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_snn_mem_mp.sv
// Directed bench for snn_mem_mp (DEPTH=10): reset, write-first bypass, range handling, stall, mid-run reset.
// Builds with or without SNN_MEM_ADDR_CHECK_EN.
module tb_snn_mem_mp;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 10;
  localparam int NUM_RD = 2;
  localparam int ADDR_W = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     wr_valid;
  logic                     wr_ready;
  logic [ADDR_W-1:0]        wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic [NUM_RD-1:0]        rd_req_valid;
  logic [NUM_RD-1:0]        rd_req_ready;
  logic [NUM_RD*ADDR_W-1:0] rd_req_addr;
  logic [NUM_RD-1:0]        rd_rsp_valid;
  logic [NUM_RD-1:0]        rd_rsp_ready;
  logic [NUM_RD*WIDTH-1:0]  rd_rsp_data;
`ifdef SNN_MEM_ADDR_CHECK_EN
  logic                     addr_err;
  logic [7:0]               err_cnt;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  snn_mem_mp #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data)
`ifdef SNN_MEM_ADDR_CHECK_EN
    ,
    .addr_err     (addr_err),
    .err_cnt      (err_cnt)
`endif
  );

  typedef struct {
    logic       wv;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [1:0] rv;
    logic [3:0] ra0;
    logic [3:0] ra1;
    logic [7:0] exp0;
    logic [7:0] exp1;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wv, input logic [3:0] wa, input logic [7:0] wd,
                       input logic [1:0] rv, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [1:0] rr);
    wr_valid     = wv;
    wr_addr      = wa;
    wr_data      = wd;
    rd_req_valid = rv;
    rd_req_addr  = {a1, a0};
    rd_rsp_ready = rr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q [4];
    logic [7:0] held;
    logic       stalled_prev;
    int         issued;
    int         popped;

    //          wv    wa    wd     rv     ra0   ra1   exp0   exp1
    vecs[0]  = '{1'b1, 4'd3, 8'hA5, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 4'd0, 8'h00, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00};
    vecs[2]  = '{1'b1, 4'd7, 8'h3C, 2'b11, 4'd7, 4'd7, 8'h3C, 8'h3C};
    vecs[3]  = '{1'b1, 4'd0, 8'h11, 2'b11, 4'd0, 4'd3, 8'h11, 8'hA5};
    vecs[4]  = '{1'b1, 4'd12, 8'hFF, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 4'd0, 8'h00, 2'b11, 4'd12, 4'd9, 8'h00, 8'h00};
    vecs[6]  = '{1'b1, 4'd9, 8'h22, 2'b11, 4'd7, 4'd9, 8'h3C, 8'h22};
    vecs[7]  = '{1'b1, 4'd10, 8'h44, 2'b01, 4'd10, 4'd0, 8'h00, 8'h00};
    vecs[8]  = '{1'b0, 4'd0, 8'h00, 2'b11, 4'd9, 4'd0, 8'h22, 8'h11};
    vecs[9]  = '{1'b1, 4'd1, 8'hB1, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00};
    vecs[10] = '{1'b1, 4'd2, 8'hB2, 2'b01, 4'd1, 4'd0, 8'hB1, 8'h00};
    vecs[11] = '{1'b0, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00};

    // Reset held for 3 cycles
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0, 2'b11);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_req_ready", rd_req_ready, 2'b00);
    chk("rst_rsp_valid", rd_rsp_valid, 2'b00);
    chk("rst_rsp_data", rd_rsp_data, 16'h0000);
    rst_n = 1'b1;
    #1;
    chk("wr_ready_up", wr_ready, 1'b1);
    chk("req_ready_up", rd_req_ready, 2'b11);

    // Reads of every address after reset return 0 (10..15 are out of range)
    for (int k = 0; k <= 16; k++) begin
      drive(1'b0, 4'd0, 8'h00, (k < 16) ? 2'b01 : 2'b00, 4'(k), 4'd0, 2'b11);
      @(posedge clk);
      #1;
      if (k < 16) begin
        chk($sformatf("rst_read_valid[%0d]", k), rd_rsp_valid[0], 1'b1);
        chk($sformatf("rst_read_data[%0d]", k), rd_rsp_data[7:0], 8'h00);
      end
      $display("reset read addr %0d data %0h", k, rd_rsp_data[7:0]);
    end

    // Table-driven single-cycle transactions, both response ports always ready
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra0, vecs[i].ra1, 2'b11);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), rd_rsp_valid, vecs[i].rv);
      if (vecs[i].rv[0]) chk($sformatf("vec%0d_data0", i), rd_rsp_data[7:0], vecs[i].exp0);
      if (vecs[i].rv[1]) chk($sformatf("vec%0d_data1", i), rd_rsp_data[15:8], vecs[i].exp1);
      $display("vec %0d wr %0b@%0d=%0h rd %b -> valid %b data %0h/%0h",
               i, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rv, rd_rsp_valid,
               rd_rsp_data[7:0], rd_rsp_data[15:8]);
    end

`ifdef SNN_MEM_ADDR_CHECK_EN
    chk("err_cnt_total", err_cnt, 8'd10);
`endif

    // Port 1: four back-to-back reads of addr 0..3, consumer stalls on cycles 2..4
    exp_q        = '{8'h11, 8'hB1, 8'hB2, 8'hA5};
    issued       = 0;
    popped       = 0;
    held         = '0;
    stalled_prev = 1'b0;
    for (int k = 0; k < 20 && popped < 4; k++) begin
      drive(1'b0, 4'd0, 8'h00, (issued < 4) ? 2'b10 : 2'b00, 4'd0, 4'(issued),
            (k >= 2 && k <= 4) ? 2'b01 : 2'b11);
      #1;
      if (stalled_prev) chk($sformatf("stall_hold_c%0d", k), rd_rsp_data[15:8], held);
      if (rd_rsp_valid[1] && !rd_rsp_ready[1]) chk($sformatf("stall_ready_c%0d", k), rd_req_ready[1], 1'b0);
      held         = rd_rsp_data[15:8];
      stalled_prev = rd_rsp_valid[1] && !rd_rsp_ready[1];
      if (rd_rsp_valid[1] && rd_rsp_ready[1]) begin
        chk($sformatf("stream_data%0d", popped), rd_rsp_data[15:8], exp_q[popped]);
        $display("stream cycle %0d pop %0d data %0h", k, popped, rd_rsp_data[15:8]);
        popped++;
      end
      if (rd_req_valid[1] && rd_req_ready[1]) issued++;
      @(posedge clk);
      #1;
    end
    chk("stream_count", popped, 4);

    // Reset while port 0 is full and stalled
    drive(1'b0, 4'd0, 8'h00, 2'b01, 4'd3, 4'd0, 2'b00);
    @(posedge clk);
    #1;
    rd_req_valid = 2'b00;
    chk("pre_rst_valid", rd_rsp_valid[0], 1'b1);
    chk("pre_rst_data", rd_rsp_data[7:0], 8'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rd_rsp_valid, 2'b00);
    chk("async_rst_req_ready", rd_req_ready, 2'b00);
    $display("mid-run reset: valid %b", rd_rsp_valid);
    repeat (2) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    rd_rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_valid%0d", k), rd_rsp_valid, 2'b00);
    end
`ifdef SNN_MEM_ADDR_CHECK_EN
    chk("post_rst_err_cnt", err_cnt, 8'd0);
`endif
    drive(1'b0, 4'd0, 8'h00, 2'b01, 4'd3, 4'd0, 2'b11);
    @(posedge clk);
    #1;
    chk("post_rst_mem_cleared", rd_rsp_data[7:0], 8'h00);
    chk("post_rst_read_valid", rd_rsp_valid[0], 1'b1);
    $display("post reset read addr 3 data %0h", rd_rsp_data[7:0]);
    rd_req_valid = 2'b00;
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
